// File: rtl/guess_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : guess_word_assembler_pkg
//  Description : Shared constants and state encoding for the guess word
//                assembler (letter geometry, key codes, ASCII ranges).
//  Revision    : 1.0 - initial release
// ============================================================================
package guess_word_assembler_pkg;

  localparam int LETTERS = 5;
  localparam int CHAR_W  = 8;
  localparam int WORD_W  = LETTERS * CHAR_W;

  localparam logic [7:0] KEY_BS      = 8'h08;
  localparam logic [7:0] KEY_ENTER   = 8'h0D;

  localparam logic [7:0] ASCII_UP_A  = 8'h41;
  localparam logic [7:0] ASCII_UP_Z  = 8'h5A;
  localparam logic [7:0] ASCII_LO_A  = 8'h61;
  localparam logic [7:0] ASCII_LO_Z  = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_t;

endpackage : guess_word_assembler_pkg
`default_nettype wire

// File: rtl/guess_word_assembler_key_classify.sv
`default_nettype none
// ============================================================================
//  Module      : guess_word_assembler_key_classify
//  Description : Combinational key decoder. Flags letters (either case),
//                backspace and enter, and folds lowercase letters to
//                uppercase.
//  Ports       : i_key_code     - raw ASCII key code
//                o_is_letter    - code is 'A'..'Z' or 'a'..'z'
//                o_is_bs        - code is the backspace key
//                o_is_enter     - code is the enter key
//                o_letter_upper - uppercase form of the letter
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_word_assembler_key_classify
  import guess_word_assembler_pkg::*;
#(
  parameter logic [7:0] KEY_BS_CODE    = guess_word_assembler_pkg::KEY_BS,
  parameter logic [7:0] KEY_ENTER_CODE = guess_word_assembler_pkg::KEY_ENTER
) (
  input  logic [7:0] i_key_code,
  output logic       o_is_letter,
  output logic       o_is_bs,
  output logic       o_is_enter,
  output logic [7:0] o_letter_upper
);

  logic w_is_upper;
  logic w_is_lower;

  assign w_is_upper     = (i_key_code >= ASCII_UP_A) && (i_key_code <= ASCII_UP_Z);
  assign w_is_lower     = (i_key_code >= ASCII_LO_A) && (i_key_code <= ASCII_LO_Z);
  assign o_is_letter    = w_is_upper || w_is_lower;
  assign o_is_bs        = (i_key_code == KEY_BS_CODE);
  assign o_is_enter     = (i_key_code == KEY_ENTER_CODE);
  assign o_letter_upper = w_is_lower ? (i_key_code - CASE_OFFSET) : i_key_code;

endmodule : guess_word_assembler_key_classify
`default_nettype wire

// File: rtl/guess_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : guess_word_assembler
//  Description : Collects key strobes into a 5-letter uppercase guess and
//                hands it to the guess register over a valid/ack handshake.
//  Ports       : clk          - rising-edge clock
//                clr          - asynchronous active-low clear
//                key_valid    - key_code qualifier strobe
//                key_code     - ASCII key code
//                word_out     - packed letters, letter 0 in the MSB byte
//                word_valid   - complete guess held in word_out
//                word_ack     - consumer accepts word_out
//                word_load    - word_valid & word_ack (guess register ie)
//                letter_count - letters currently buffered
//                enter_err    - one-cycle pulse on a premature enter
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_word_assembler
  import guess_word_assembler_pkg::*;
#(
  parameter logic [7:0] KEY_BS_CODE    = guess_word_assembler_pkg::KEY_BS,
  parameter logic [7:0] KEY_ENTER_CODE = guess_word_assembler_pkg::KEY_ENTER
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ack,
  output logic              word_load,
  output logic [2:0]        letter_count,
  output logic              enter_err
);

  localparam logic [2:0] c_FULL = 3'(LETTERS);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_count;
  logic [2:0] w_count_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic       w_store;
  logic       w_erase;
  logic       w_flush;

  logic       w_is_letter;
  logic       w_is_bs;
  logic       w_is_enter;
  logic [7:0] w_letter_upper;

  guess_word_assembler_key_classify #(
    .KEY_BS_CODE    (KEY_BS_CODE),
    .KEY_ENTER_CODE (KEY_ENTER_CODE)
  ) u_classify (
    .i_key_code     (key_code),
    .o_is_letter    (w_is_letter),
    .o_is_bs        (w_is_bs),
    .o_is_enter     (w_is_enter),
    .o_letter_upper (w_letter_upper)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= COLLECT;
      r_count <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Keys are only interpreted in COLLECT; in ISSUE the buffer is frozen
  // until the consumer acknowledges, which flushes it in one step.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
    w_store     = 1'b0;
    w_erase     = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      COLLECT: begin
        if (key_valid) begin
          if (w_is_letter) begin
            if (r_count < c_FULL) begin
              w_store     = 1'b1;
              w_count_nxt = r_count + 3'd1;
            end
          end else if (w_is_bs) begin
            if (r_count != 3'd0) begin
              w_erase     = 1'b1;
              w_count_nxt = r_count - 3'd1;
            end
          end else if (w_is_enter) begin
            if (r_count == c_FULL) begin
              w_state_nxt = ISSUE;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (word_ack) begin
          w_flush     = 1'b1;
          w_count_nxt = 3'd0;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // One enabled byte register per letter position. A store targets the
  // slot at the current count; a backspace clears the slot just below it.
  for (genvar i = 0; i < LETTERS; i++) begin : g_slot
    logic [CHAR_W-1:0] r_slot;

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        r_slot <= '0;
      end else if (w_flush) begin
        r_slot <= '0;
      end else if (w_store && (r_count == 3'(i))) begin
        r_slot <= w_letter_upper;
      end else if (w_erase && (r_count == 3'(i + 1))) begin
        r_slot <= '0;
      end
    end

    assign word_out[WORD_W-1-CHAR_W*i -: CHAR_W] = r_slot;
  end

  assign word_valid   = (r_state == ISSUE);
  assign word_load    = (r_state == ISSUE) && word_ack;
  assign letter_count = r_count;
  assign enter_err    = r_err;

endmodule : guess_word_assembler
`default_nettype wire

// File: tb/tb_guess_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_word_assembler
//  Description : Self-checking bench for guess_word_assembler. The driver
//                keeps a letter-queue reference model and pushes expected
//                per-cycle outputs and expected loaded words into queues;
//                a monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_word_assembler;

  logic        clk;
  logic        clr;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [39:0] word_out;
  logic        word_valid;
  logic        word_ack;
  logic        word_load;
  logic [2:0]  letter_count;
  logic        enter_err;

  guess_word_assembler dut (
    .clk          (clk),
    .clr          (clr),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ack     (word_ack),
    .word_load    (word_load),
    .letter_count (letter_count),
    .enter_err    (enter_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cnt;
    logic [39:0] word;
    logic        valid;
    logic        err;
    logic        load;
  } snap_t;

  snap_t       exp_q[$];
  logic [39:0] load_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: typed letters as a plain queue, plus issue/error flags.
  logic [7:0] m_buf[$];
  bit         m_issue;
  bit         m_err;

  function automatic logic [39:0] pack_word();
    logic [39:0] w;
    w = '0;
    for (int i = 0; i < m_buf.size(); i++)
      w = w | (40'(m_buf[i]) << (8 * (4 - i)));
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one clock cycle of stimulus starting at posedge+1; returns at the
  // next posedge+1 with the model advanced to the new DUT state.
  task automatic cycle(input logic kv, input logic [7:0] code, input logic ack);
    snap_t s;
    key_valid = kv;
    key_code  = code;
    word_ack  = ack;
    s.cnt   = 3'(m_buf.size());
    s.word  = pack_word();
    s.valid = m_issue;
    s.err   = m_err;
    s.load  = m_issue && ack;
    exp_q.push_back(s);
    if (s.load) load_q.push_back(s.word);
    m_err = 1'b0;
    if (m_issue) begin
      if (ack) begin
        m_buf.delete();
        m_issue = 1'b0;
      end
    end else if (kv) begin
      if (code >= "A" && code <= "Z") begin
        if (m_buf.size() < 5) m_buf.push_back(code);
      end else if (code >= "a" && code <= "z") begin
        if (m_buf.size() < 5) m_buf.push_back(code - 8'd32);
      end else if (code == 8'h08) begin
        if (m_buf.size() > 0) void'(m_buf.pop_back());
      end else if (code == 8'h0D) begin
        if (m_buf.size() == 5) m_issue = 1'b1;
        else m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] code);
    cycle(1'b1, code, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t s;
      s = exp_q.pop_front();
      chk("letter_count", 64'(letter_count), 64'(s.cnt));
      chk("word_out",     64'(word_out),     64'(s.word));
      chk("word_valid",   64'(word_valid),   64'(s.valid));
      chk("enter_err",    64'(enter_err),    64'(s.err));
      chk("word_load",    64'(word_load),    64'(s.load));
      if (word_load) begin
        if (load_q.size() == 0) begin
          chk("unexpected_load", 64'(word_out), 64'h0);
        end else begin
          logic [39:0] w;
          w = load_q.pop_front();
          chk("loaded_word", 64'(word_out), 64'(w));
        end
      end
    end
  end

  initial begin
    logic [7:0] code;
    int r;
    clr       = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    word_ack  = 1'b0;
    m_issue   = 1'b0;
    m_err     = 1'b0;

    // Reset state
    #2;
    chk("rst_count", 64'(letter_count), 64'h0);
    chk("rst_word",  64'(word_out),     64'h0);
    chk("rst_valid", 64'(word_valid),   64'h0);
    chk("rst_err",   64'(enter_err),    64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;

    // Basic word: "crane"
    key("c"); chk("count_1", 64'(letter_count), 64'd1);
    key("r"); chk("count_2", 64'(letter_count), 64'd2);
    key("a"); key("n"); key("e");
    chk("count_5", 64'(letter_count), 64'd5);
    chk("valid_before_enter", 64'(word_valid), 64'h0);
    key(8'h0D);
    chk("valid_after_enter", 64'(word_valid), 64'h1);
    chk("crane_word", 64'(word_out), 64'h4352414E45);

    // Ack with a simultaneous key: key must be dropped
    cycle(1'b1, "x", 1'b1);
    chk("post_ack_count", 64'(letter_count), 64'h0);
    chk("post_ack_word",  64'(word_out),     64'h0);
    chk("post_ack_valid", 64'(word_valid),   64'h0);
    // Ack held while collecting must not load
    cycle(1'b0, 8'h00, 1'b1);

    // Backspace editing
    key("A"); key("B"); key("C"); key(8'h08); key(8'h08); key("Z");
    chk("bs_count", 64'(letter_count), 64'd2);
    chk("bs_word",  64'(word_out),     64'h415A000000);
    key(8'h08); key(8'h08);

    // Premature enter and overflow letter
    key("Q"); key("w"); key("E"); key(8'h0D);
    chk("err_pulse", 64'(enter_err), 64'h1);
    idle();
    chk("err_cleared", 64'(enter_err), 64'h0);
    chk("err_no_valid", 64'(word_valid), 64'h0);
    key("r"); key("T"); key("y");
    chk("overflow_count", 64'(letter_count), 64'd5);
    chk("overflow_word", 64'(word_out), 64'h5157455254);
    for (int i = 0; i < 5; i++) key(8'h08);

    // Ignored codes and backspace at zero
    key("1"); key(8'h20); key(8'h7B); key(8'h08); key(8'h40); key(8'h60);
    chk("ignored_count", 64'(letter_count), 64'h0);
    chk("ignored_word",  64'(word_out),     64'h0);

    // Asynchronous clear while issuing
    key("P"); key("l"); key("A"); key("n"); key("T"); key(8'h0D);
    chk("pre_clr_valid", 64'(word_valid), 64'h1);
    #2;
    word_ack = 1'b1;
    clr = 1'b0;
    #1;
    chk("clr_valid", 64'(word_valid),   64'h0);
    chk("clr_count", 64'(letter_count), 64'h0);
    chk("clr_word",  64'(word_out),     64'h0);
    chk("clr_err",   64'(enter_err),    64'h0);
    chk("clr_load",  64'(word_load),    64'h0);
    m_buf.delete();
    m_issue = 1'b0;
    m_err   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    word_ack = 1'b0;
    clr = 1'b1;
    key("S"); key("t"); key("o"); key("n"); key("E"); key(8'h0D);
    chk("after_clr_word", 64'(word_out), 64'h53544F4E45);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      code = 8'h41 + 8'($urandom_range(0, 25));
      else if (r < 60) code = 8'h61 + 8'($urandom_range(0, 25));
      else if (r < 70) code = 8'h08;
      else if (r < 80) code = 8'h0D;
      else             code = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 3) != 0), code, ($urandom_range(0, 2) == 0));
    end
    idle();
    @(negedge clk);
    #1;
    chk("exp_q_drained",  64'(exp_q.size()),  64'h0);
    chk("load_q_drained", 64'(load_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_guess_word_assembler
`default_nettype wire

// File: doc/guess_word_assembler.md
Name: guess_word_assembler

Overview:
- Builds one 5-letter guess from a stream of single-character key strobes.
- Packs the letters into a 40-bit word: 5 letters x 8-bit uppercase ASCII.
- Presents the word to the downstream 40-bit guess register through a valid/ack handshake.
- Supplies that register's data input and a one-cycle load strobe for its ie.
- Sits between the keyboard decode logic and the guess register feeding the compare datapath.

Parameters:
- LETTERS, 5: letters per guess.
- CHAR_W, 8: bits per letter.
- KEY_BS, 8'h08: backspace code.
- KEY_ENTER, 8'h0D: enter code.
- WORD_W is derived as LETTERS*CHAR_W (40); it is a localparam, not overridable.

Ports:
- clk, input, 1: rising-edge clock.
- clr, input, 1: asynchronous, active-low reset (0 clears all state).
- key_valid, input, 1: one-cycle strobe; key_code is valid this cycle.
- key_code, input, 8: ASCII key code.
- word_out, output, 40: packed guess; letter 0 (first typed) in [39:32], letter 4 in [7:0].
- word_valid, output, 1: a complete guess is held in word_out.
- word_ack, input, 1: consumer accepts word_out.
- word_load, output, 1: word_valid & word_ack (combinational); drives the guess register's ie.
- letter_count, output, 3: letters currently buffered, 0..5.
- enter_err, output, 1: one-cycle pulse when enter is pressed with fewer than 5 letters.

Behaviour:
- Reset (clr=0, asynchronous): state=COLLECT, buffer=0, letter_count=0, word_out=0, word_valid=0, enter_err=0. Reset mid-ISSUE discards the pending word; no word_load occurs.
- Key classification:
  - Letter: 'A'..'Z' (8'h41-8'h5A) is stored as-is; 'a'..'z' (8'h61-8'h7A) is stored minus 8'h20.
  - Any other code except KEY_BS and KEY_ENTER is ignored; no state change.
- State COLLECT (word_valid=0):
  - letter and count<5: store in slot count (bits [39-8*count -: 8]); count++ next cycle.
  - letter and count==5: dropped; buffer unchanged.
  - KEY_BS and count>0: slot count-1 zeroed; count--.
  - KEY_BS and count==0: ignored.
  - KEY_ENTER and count==5: go to ISSUE next cycle.
  - KEY_ENTER and count<5: enter_err=1 for exactly the next cycle; stay in COLLECT; buffer unchanged.
- State ISSUE (word_valid=1):
  - word_out holds the buffer and is stable until accepted.
  - All key strobes are ignored and dropped; letter_count stays 5.
  - word_ack=1: word_load=1 that same cycle; next cycle buffer=0, count=0, word_valid=0, state=COLLECT.
  - word_ack held high while in COLLECT has no effect (word_load=0).
- word_out is the live buffer in COLLECT, so partially typed letters are visible for display. Consumers must qualify with word_valid/word_load.
- Latency:
  - Enter strobe to word_valid is 1 cycle.
  - A key arriving the cycle after ack is accepted normally.
- All outputs are registered except word_load.

Decomposition:
- Shared package holds:
  - LETTERS, CHAR_W, WORD_W.
  - Key constants KEY_BS and KEY_ENTER, plus ASCII range bounds.
  - State encoding COLLECT=1'b0, ISSUE=1'b1.
- One sub-module is natural: key_classify.
  - Combinational.
  - Inputs: key_code.
  - Outputs: is_letter, is_bs, is_enter, letter_upper[7:0].
- The buffer is 5 per-slot 8-bit enabled flops; the count and FSM live in the top module.

Test Plan:
- Reset, then keys 'c','r','a','n','e', then ENTER.
  - letter_count steps 1..5.
  - word_valid rises 1 cycle after ENTER.
  - word_out=40'h4352414E45.
- In ISSUE, pulse word_ack with key 'x' on the same cycle.
  - word_load=1 that cycle.
  - Next cycle: count=0, word_out=0, word_valid=0.
  - 'x' is not stored.
- Keys 'A','B','C', BS, BS, 'Z'.
  - count=2.
  - word_out[39:24]=16'h415A; remaining bits 0.
- Three letters then ENTER.
  - enter_err is a 1-cycle pulse; word_valid stays 0.
  - A sixth letter after 5 letters is dropped; count stays 5.
- Keys '1', 8'h20, 8'h7B, and BS at count 0: no change to count or word_out.
- Enter 5 letters, reach ISSUE, assert clr=0 mid-cycle.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a new word assembles correctly.
